// File: rtl/game_turn_ctl.sv
// Turn controller for a two-player battleship board: ship placement clicks,
// shot/answer handshake with the peer, hit counting and win/lose detection.
module game_turn_ctl #(
    parameter int GRID_N      = 10,
    parameter int CELL_LOG2   = 5,
    parameter int GRID_X0     = 608,
    parameter int GRID_Y0     = 193,
    parameter int SHIPS       = 10,
    parameter int HITS_TO_WIN = 20,
    parameter int CW          = $clog2(GRID_N),
    parameter int CNT         = $clog2(HITS_TO_WIN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       start_button,
    input  logic                       mouse_left,
    input  logic [11:0]                mouse_xpos,
    input  logic [11:0]                mouse_ypos,
    input  logic                       first_player,
    input  logic                       peer_ready,
    input  logic                       turn_pass,
    input  logic                       peer_won,
    input  logic                       answer_valid,
    input  logic                       answer_hit,
    output logic [2*CW-1:0]            cell_pos,
    output logic                       pick_ship,
    output logic                       shot_valid,
    output logic [$clog2(SHIPS+1)-1:0] ship_count,
    output logic [CNT-1:0]             hit_count,
    output logic [2:0]                 state_o,
    output logic                       game_won,
    output logic                       game_lost
);
    localparam int SCW = $clog2(SHIPS + 1);
    localparam logic [12:0] X_LO = 13'(GRID_X0);
    localparam logic [12:0] X_HI = 13'(GRID_X0 + (GRID_N << CELL_LOG2));
    localparam logic [12:0] Y_LO = 13'(GRID_Y0);
    localparam logic [12:0] Y_HI = 13'(GRID_Y0 + (GRID_N << CELL_LOG2));
    localparam logic [SCW-1:0] SHIPS_W = SCW'(SHIPS);
    localparam logic [CNT-1:0] HITS_W  = CNT'(HITS_TO_WIN);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLACE      = 3'd1,
        WAIT_PEER  = 3'd2,
        MY_TURN    = 3'd3,
        WAIT_ANS   = 3'd4,
        THEIR_TURN = 3'd5,
        OVER       = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [2*CW-1:0] cell_pos_q, cell_pos_d;
    logic            pick_ship_q, pick_ship_d;
    logic            shot_valid_q, shot_valid_d;
    logic [SCW-1:0]  ship_count_q, ship_count_d;
    logic [CNT-1:0]  hit_count_q, hit_count_d;
    logic            game_won_q, game_won_d;
    logic            game_lost_q, game_lost_d;
    logic            mouse_prev_q, mouse_prev_d;

    logic [12:0]     xe, ye, dx, dy;
    logic            in_grid, click_in;
    logic [2*CW-1:0] click_cell;

    // The button is only looked at once per frame, so a click is a rising
    // edge between two consecutive frame samples.
    always_comb begin
        xe         = {1'b0, mouse_xpos};
        ye         = {1'b0, mouse_ypos};
        dx         = xe - X_LO;
        dy         = ye - Y_LO;
        in_grid    = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI);
        click_in   = frame_tick && mouse_left && !mouse_prev_q && in_grid;
        click_cell = {CW'(dy >> CELL_LOG2), CW'(dx >> CELL_LOG2)};
    end

    always_comb begin
        state_d      = state_q;
        cell_pos_d   = cell_pos_q;
        pick_ship_d  = 1'b0;
        ship_count_d = ship_count_q;
        hit_count_d  = hit_count_q;
        game_won_d   = game_won_q;
        game_lost_d  = game_lost_q;
        mouse_prev_d = frame_tick ? mouse_left : mouse_prev_q;
        case (state_q)
            IDLE:
                if (frame_tick && start_button) state_d = PLACE;
            PLACE:
                if (click_in) begin
                    cell_pos_d   = click_cell;
                    pick_ship_d  = 1'b1;
                    ship_count_d = ship_count_q + SCW'(1);
                    if (ship_count_d == SHIPS_W) state_d = WAIT_PEER;
                end
            WAIT_PEER:
                if (peer_ready) state_d = first_player ? MY_TURN : THEIR_TURN;
            MY_TURN:
                if (click_in) begin
                    cell_pos_d = click_cell;
                    state_d    = WAIT_ANS;
                end
            WAIT_ANS:
                // Losing outranks any answer arriving in the same cycle.
                if (peer_won) begin
                    state_d     = OVER;
                    game_lost_d = 1'b1;
                end else if (answer_valid) begin
                    if (answer_hit) begin
                        hit_count_d = hit_count_q + CNT'(1);
                        if (hit_count_d == HITS_W) begin
                            state_d    = OVER;
                            game_won_d = 1'b1;
                        end else begin
                            state_d = MY_TURN;
                        end
                    end else begin
                        state_d = THEIR_TURN;
                    end
                end
            THEIR_TURN:
                if (peer_won) begin
                    state_d     = OVER;
                    game_lost_d = 1'b1;
                end else if (turn_pass) begin
                    state_d = MY_TURN;
                end
            OVER:
                if (frame_tick && start_button) begin
                    state_d      = IDLE;
                    cell_pos_d   = '0;
                    ship_count_d = '0;
                    hit_count_d  = '0;
                    game_won_d   = 1'b0;
                    game_lost_d  = 1'b0;
                end
            default: state_d = IDLE;
        endcase
        shot_valid_d = (state_d == WAIT_ANS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cell_pos_q   <= '0;
            pick_ship_q  <= 1'b0;
            shot_valid_q <= 1'b0;
            ship_count_q <= '0;
            hit_count_q  <= '0;
            game_won_q   <= 1'b0;
            game_lost_q  <= 1'b0;
            mouse_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_pos_q   <= cell_pos_d;
            pick_ship_q  <= pick_ship_d;
            shot_valid_q <= shot_valid_d;
            ship_count_q <= ship_count_d;
            hit_count_q  <= hit_count_d;
            game_won_q   <= game_won_d;
            game_lost_q  <= game_lost_d;
            mouse_prev_q <= mouse_prev_d;
        end
    end

    assign state_o    = 3'(state_q);
    assign cell_pos   = cell_pos_q;
    assign pick_ship  = pick_ship_q;
    assign shot_valid = shot_valid_q;
    assign ship_count = ship_count_q;
    assign hit_count  = hit_count_q;
    assign game_won   = game_won_q;
    assign game_lost  = game_lost_q;
endmodule

// File: tb/tb_game_turn_ctl.sv
// Directed bench for game_turn_ctl: placement, shooting, win/lose and reset.
module tb_game_turn_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0, start_button = 1'b0, mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
    logic        first_player = 1'b1, peer_ready = 1'b0, turn_pass = 1'b0;
    logic        peer_won = 1'b0, answer_valid = 1'b0, answer_hit = 1'b0;
    logic [7:0]  cell_pos;
    logic        pick_ship, shot_valid, game_won, game_lost;
    logic [3:0]  ship_count;
    logic [4:0]  hit_count;
    logic [2:0]  state_o;
    int n_checks = 0;
    int n_fail   = 0;

    game_turn_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_button(start_button),
        .mouse_left(mouse_left), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .first_player(first_player), .peer_ready(peer_ready), .turn_pass(turn_pass),
        .peer_won(peer_won), .answer_valid(answer_valid), .answer_hit(answer_hit),
        .cell_pos(cell_pos), .pick_ship(pick_ship), .shot_valid(shot_valid),
        .ship_count(ship_count), .hit_count(hit_count), .state_o(state_o),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    // Stimulus drivers: inputs change on negedge, outputs are read on the next negedge.
    task automatic frame(input logic ml);
        @(negedge clk); frame_tick = 1'b1; mouse_left = ml;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic click(input int x, input int y);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y);
        frame(1'b0);
        frame(1'b1);
    endtask

    task automatic press_start();
        @(negedge clk); frame_tick = 1'b1; start_button = 1'b1;
        @(negedge clk); frame_tick = 1'b0; start_button = 1'b0;
    endtask

    task automatic answer(input logic hit, input logic pw);
        @(negedge clk); answer_valid = 1'b1; answer_hit = hit; peer_won = pw;
        @(negedge clk); answer_valid = 1'b0; answer_hit = 1'b0; peer_won = 1'b0;
    endtask

    task automatic pulse_ready(input logic fp);
        @(negedge clk); peer_ready = 1'b1; first_player = fp;
        @(negedge clk); peer_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic place_all();
        press_start();
        for (int i = 0; i < 10; i++) click(624 + 32 * i, 209);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({state_o, cell_pos, ship_count, hit_count, pick_ship, shot_valid, game_won, game_lost} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d pos=%h sc=%0d hc=%0d ps=%b sv=%b w=%b l=%b, want all 0",
                     state_o, cell_pos, ship_count, hit_count, pick_ship, shot_valid, game_won, game_lost);
        end
    endtask

    task automatic test_start();
        @(negedge clk); start_button = 1'b1;
        @(negedge clk); start_button = 1'b0;
        n_checks++;
        if (state_o !== 3'd0) begin n_fail++; $display("FAIL start_no_tick: got %0d want 0", state_o); end
        press_start();
        n_checks++;
        if (state_o !== 3'd1) begin n_fail++; $display("FAIL start_to_place: got %0d want 1", state_o); end
    endtask

    task automatic test_place_bounds();
        int pulses;
        click(607, 300);
        click(928, 300);
        click(700, 192);
        n_checks++;
        if (ship_count !== 4'd0 || state_o !== 3'd1) begin
            n_fail++; $display("FAIL out_of_grid: got sc=%0d st=%0d want sc=0 st=1", ship_count, state_o);
        end
        mouse_xpos = 12'd624; mouse_ypos = 12'd209;
        frame(1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            frame(1'b1);
            if (pick_ship === 1'b1) pulses++;
        end
        frame(1'b0);
        n_checks++;
        if (pulses != 1 || ship_count !== 4'd1) begin
            n_fail++; $display("FAIL held_button: got pulses=%0d sc=%0d want 1 1", pulses, ship_count);
        end
    endtask

    task automatic test_place();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            click(624 + 32 * i, 209);
            if (pick_ship === 1'b1) pulses++;
            n_checks++;
            if (cell_pos !== 8'(i) || ship_count !== 4'(i + 1)) begin
                n_fail++; $display("FAIL place_%0d: got pos=%h sc=%0d want pos=%h sc=%0d",
                                   i, cell_pos, ship_count, 8'(i), i + 1);
            end
            @(negedge clk);
            if (pick_ship !== 1'b0) pulses += 100;
        end
        n_checks++;
        if (pulses != 10) begin n_fail++; $display("FAIL pick_pulses: got %0d want 10", pulses); end
        n_checks++;
        if (state_o !== 3'd2) begin n_fail++; $display("FAIL place_done: got st=%0d want 2", state_o); end
    endtask

    task automatic test_turns();
        click(640, 225);
        n_checks++;
        if (state_o !== 3'd2) begin n_fail++; $display("FAIL wait_peer_click: got st=%0d want 2", state_o); end
        pulse_ready(1'b1);
        n_checks++;
        if (state_o !== 3'd3) begin n_fail++; $display("FAIL first_shooter: got st=%0d want 3", state_o); end
        click(640, 225);
        n_checks++;
        if (cell_pos !== 8'h11 || shot_valid !== 1'b1 || state_o !== 3'd4) begin
            n_fail++; $display("FAIL shot1: got pos=%h sv=%b st=%0d want 11 1 4", cell_pos, shot_valid, state_o);
        end
        answer(1'b1, 1'b0);
        n_checks++;
        if (state_o !== 3'd3 || hit_count !== 5'd1 || shot_valid !== 1'b0) begin
            n_fail++; $display("FAIL hit1: got st=%0d hc=%0d sv=%b want 3 1 0", state_o, hit_count, shot_valid);
        end
        click(700, 300);
        n_checks++;
        if (cell_pos !== 8'h32 || state_o !== 3'd4) begin
            n_fail++; $display("FAIL shot2: got pos=%h st=%0d want 32 4", cell_pos, state_o);
        end
        answer(1'b0, 1'b0);
        n_checks++;
        if (state_o !== 3'd5 || hit_count !== 5'd1) begin
            n_fail++; $display("FAIL miss: got st=%0d hc=%0d want 5 1", state_o, hit_count);
        end
        @(negedge clk); turn_pass = 1'b1;
        @(negedge clk); turn_pass = 1'b0;
        n_checks++;
        if (state_o !== 3'd3) begin n_fail++; $display("FAIL turn_pass: got st=%0d want 3", state_o); end
    endtask

    task automatic test_win();
        for (int i = 0; i < 18; i++) begin
            click(640, 225);
            answer(1'b1, 1'b0);
        end
        click(640, 225);
        n_checks++;
        if (hit_count !== 5'd19 || state_o !== 3'd4) begin
            n_fail++; $display("FAIL pre_win: got hc=%0d st=%0d want 19 4", hit_count, state_o);
        end
        answer(1'b1, 1'b0);
        n_checks++;
        if (game_won !== 1'b1 || game_lost !== 1'b0 || state_o !== 3'd6 || hit_count !== 5'd20) begin
            n_fail++; $display("FAIL win: got w=%b l=%b st=%0d hc=%0d want 1 0 6 20",
                               game_won, game_lost, state_o, hit_count);
        end
        press_start();
        n_checks++;
        if (state_o !== 3'd0 || hit_count !== 5'd0 || ship_count !== 4'd0 || game_won !== 1'b0 || cell_pos !== 8'h0) begin
            n_fail++; $display("FAIL restart: got st=%0d hc=%0d sc=%0d w=%b pos=%h want all 0",
                               state_o, hit_count, ship_count, game_won, cell_pos);
        end
    endtask

    task automatic test_peer_won_priority();
        place_all();
        pulse_ready(1'b1);
        click(640, 225);
        answer(1'b1, 1'b0);
        click(672, 225);
        answer(1'b1, 1'b1);
        n_checks++;
        if (game_lost !== 1'b1 || game_won !== 1'b0 || hit_count !== 5'd1 || state_o !== 3'd6) begin
            n_fail++; $display("FAIL peer_won_prio: got l=%b w=%b hc=%0d st=%0d want 1 0 1 6",
                               game_lost, game_won, hit_count, state_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        place_all();
        pulse_ready(1'b0);
        n_checks++;
        if (state_o !== 3'd5) begin n_fail++; $display("FAIL second_shooter: got st=%0d want 5", state_o); end
        @(negedge clk); turn_pass = 1'b1;
        @(negedge clk); turn_pass = 1'b0;
        click(640, 225);
        n_checks++;
        if (state_o !== 3'd4 || shot_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_shot: got st=%0d sv=%b want 4 1", state_o, shot_valid);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({state_o, cell_pos, ship_count, hit_count, pick_ship, shot_valid, game_won, game_lost} !== 24'h0) begin
            n_fail++; $display("FAIL async_reset: got st=%0d pos=%h sc=%0d sv=%b, want all 0",
                               state_o, cell_pos, ship_count, shot_valid);
        end
        @(negedge clk); rst = 1'b0;
        press_start();
        n_checks++;
        if (state_o !== 3'd1) begin n_fail++; $display("FAIL post_reset_start: got st=%0d want 1", state_o); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_place_bounds();
        do_reset();
        press_start();
        test_place();
        test_turns();
        test_win();
        test_peer_won_priority();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_turn_ctl.md
GAME_TURN_CTL -- requirements
Module: game_turn_ctl

Interface
REQ-001 The block SHALL have these parameters:
- GRID_N, 10, cells per board side.
- CELL_LOG2, 5, log2 of cell size in pixels.
- GRID_X0, 608, pixel x of the board's left edge.
- GRID_Y0, 193, pixel y of the board's top edge.
- SHIPS, 10, placement clicks required.
- HITS_TO_WIN, 20, hits required for a win.
REQ-002 The block SHALL define CW = $clog2(GRID_N) and CNT = $clog2(HITS_TO_WIN+1).
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse at hcount==0 and vcount==0.
- start_button  in  1  start or restart request.
- mouse_left  in  1  left mouse button level.
- mouse_xpos  in  12  cursor x position.
- mouse_ypos  in  12  cursor y position.
- first_player  in  1  1 means this side shoots first.
- peer_ready  in  1  opponent has finished placement.
- turn_pass  in  1  one-cycle pulse: opponent's turn has ended.
- peer_won  in  1  one-cycle pulse: opponent has won.
- answer_valid  in  1  one-cycle pulse: result of our shot.
- answer_hit  in  1  qualifies answer_valid; 1 means hit.
- cell_pos  out  2*CW  last accepted cell, {row,col}.
- pick_ship  out  1  one-cycle placement strobe.
- shot_valid  out  1  shot pending; level signal.
- ship_count  out  $clog2(SHIPS+1)  ships placed so far.
- hit_count  out  CNT  hits scored so far.
- state_o  out  3  current state encoding.
- game_won  out  1  game over, this side won.
- game_lost  out  1  game over, this side lost.

Function
REQ-004 States and encodings SHALL be IDLE=0, PLACE=1, WAIT_PEER=2, MY_TURN=3, WAIT_ANS=4, THEIR_TURN=5, OVER=6; state_o SHALL equal the current state.
REQ-005 The block SHALL sample mouse_left only on frame_tick cycles, and a click SHALL be a 0->1 change between two consecutive frame_tick samples.
REQ-006 A click SHALL be in-grid only if GRID_X0 <= x < GRID_X0+(GRID_N<<CELL_LOG2) and GRID_Y0 <= y < GRID_Y0+(GRID_N<<CELL_LOG2); any other click SHALL be ignored.
REQ-007 For in-grid clicks, row SHALL be (y-GRID_Y0)>>CELL_LOG2 and col SHALL be (x-GRID_X0)>>CELL_LOG2, each truncated to CW bits; cell_pos SHALL be {row,col}.
REQ-008 IDLE SHALL go to PLACE on a frame_tick cycle with start_button=1.
REQ-009 In PLACE, each in-grid click SHALL do all of the following on the next cycle: latch cell_pos, pulse pick_ship high for exactly 1 clk, increment ship_count.
REQ-010 PLACE SHALL go to WAIT_PEER on the same edge on which ship_count becomes SHIPS; ship_count SHALL never exceed SHIPS.
REQ-011 WAIT_PEER SHALL go to MY_TURN when peer_ready=1 and first_player=1, and to THEIR_TURN when peer_ready=1 and first_player=0; these conditions SHALL be evaluated every clk.
REQ-012 In MY_TURN, an in-grid click SHALL latch cell_pos, set shot_valid=1 on the next cycle, and go to WAIT_ANS.
REQ-013 shot_valid SHALL stay high throughout WAIT_ANS and SHALL be low in every other state.
REQ-014 In WAIT_ANS, answer_valid SHALL be evaluated every clk, not gated by frame_tick.
REQ-015 On answer_valid with answer_hit=1, hit_count SHALL increment; if the new value equals HITS_TO_WIN the state SHALL go to OVER with game_won=1, otherwise to MY_TURN (a hit shoots again).
REQ-016 On answer_valid with answer_hit=0, the state SHALL go to THEIR_TURN and hit_count SHALL be unchanged.
REQ-017 THEIR_TURN SHALL go to MY_TURN on turn_pass.
REQ-018 peer_won in THEIR_TURN or WAIT_ANS SHALL go to OVER with game_lost=1.
REQ-019 If peer_won and answer_valid occur in the same cycle, peer_won SHALL take priority.
REQ-020 answer_valid, turn_pass and peer_won SHALL be ignored in every state not listed for them above.
REQ-021 Clicks SHALL be ignored in IDLE, WAIT_PEER, WAIT_ANS, THEIR_TURN and OVER.
REQ-022 OVER SHALL go to IDLE on a frame_tick cycle with start_button=1, clearing ship_count, hit_count, game_won, game_lost and cell_pos.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 Asserting rst SHALL immediately, at any time and mid-game, force: state IDLE, all counters 0, cell_pos 0, pick_ship/shot_valid/game_won/game_lost 0, click-sample register 0.
REQ-025 After rst deasserts, the block SHALL act on the first rising clk edge that follows.

Verification
REQ-026 The bench SHALL cover: reset, then start_button on a frame_tick, then 10 clicks at (624,209)…(912,209) -> pick_ship pulses 10 times, cell_pos = {0,0}…{0,9}, state_o = 2 after the 10th.
REQ-027 The bench SHALL cover: in PLACE, clicks at (607,300), (928,300) and (700,192) -> no pick_ship, ship_count unchanged; mouse_left held high for 5 frames -> exactly one pick_ship.
REQ-028 The bench SHALL cover: peer_ready with first_player=1, then a click at (640,225) -> cell_pos = 0x11, shot_valid=1, state_o = 4; answer_valid with answer_hit=1 -> state_o = 3, hit_count = 1; a second shot answered with answer_hit=0 -> state_o = 5; turn_pass -> state_o = 3.
REQ-029 The bench SHALL cover: hit_count = 19 in WAIT_ANS, then answer_valid with answer_hit=1 -> game_won=1, state_o = 6; start_button on a frame_tick -> state_o = 0, counters 0.
REQ-030 The bench SHALL cover: peer_won and answer_valid with answer_hit=1 in the same cycle -> game_lost=1, hit_count unchanged.
REQ-031 The bench SHALL cover: rst asserted mid-WAIT_ANS between clk edges -> all outputs 0 before the next clk edge.
